egr_tu12_mc: RTL and testbench

//  Multichannel successor of the per-address TU-12 egress demapper: one instance serves NCH time-sliced TU-12s.
//  Per channel: tracks the 144-byte multiframe (V1..V4 + 140 VC-12 bytes), locates V5 from an externally

---
 rtl/egr_tu12_mc.sv | 208 ++++++++++++++++++++
 tb/tb_egr_tu12_mc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/egr_tu12_mc.sv
// egr_tu12_mc: multichannel TU-12 egress demapper.
// Serves NCH time-sliced TU-12s. Each channel keeps its own multiframe row
// counter, active/pending V5 offset, BIP-2 accumulator and payload FIFO.
// Payload FIFOs share one RAM, addressed as {channel, slot}.
module egr_tu12_mc #(
  parameter int WIDTH = 8,
  parameter int NCH   = 21,
  parameter int CHW   = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxsof,
  input  logic             din_vld,
  input  logic [CHW-1:0]   din_ch,
  input  logic [WIDTH-1:0] datain,
  input  logic             ptr_vld,
  input  logic [CHW-1:0]   ptr_ch,
  input  logic [9:0]       ptr_off,
  input  logic             rd_en,
  input  logic [CHW-1:0]   rd_ch,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             rei_vld,
  output logic [CHW-1:0]   rei_ch,
  output logic             rei_bip2,
  output logic             ovf,
  output logic             unf
);

  localparam int NSLOT = 1 << CHW;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [CW-1:0]  FULL  = CW'(DEPTH);
  localparam logic [CHW:0]   NCH_L = NCH[CHW:0];

  // V5 position in the 140-byte VC-12 area, skipping the V1..V4 rows.
  // Offsets are range-checked on entry, so the low 8 bits carry the value.
  function automatic logic [7:0] v5_row(input logic [9:0] o);
    logic [7:0] r;
    if (o <= 10'd34)       r = o[7:0] + 8'd37;
    else if (o <= 10'd69)  r = o[7:0] + 8'd38;
    else if (o <= 10'd104) r = o[7:0] + 8'd39;
    else                   r = o[7:0] - 8'd104;
    return r;
  endfunction

  // Per-channel state gathered into packed vectors for channel-indexed reads
  logic [NSLOT-1:0][7:0]    row_all;
  logic [NSLOT-1:0][9:0]    off_all;
  logic [NSLOT-1:0][1:0]    acc_all;
  logic [NSLOT-1:0]         bip_ok_all;
  logic [NSLOT-1:0][PW-1:0] wptr_all;
  logic [NSLOT-1:0][PW-1:0] rptr_all;
  logic [NSLOT-1:0][CW-1:0] cnt_all;

  logic [WIDTH-1:0] mem [NSLOT*DEPTH];

  logic       din_hit;
  logic [7:0] cur_row;
  logic [7:0] cur_v5;
  logic       cur_ptr;
  logic       cur_is_v5;
  logic [1:0] byte_par;
  logic       wr_req;
  logic       wr_ok;
  logic       rd_ok;
  logic       rei_fire;

  // A byte in the rxsof cycle or for a non-existent channel is dropped
  assign din_hit   = din_vld && !rxsof && ({1'b0, din_ch} < NCH_L);
  assign cur_row   = row_all[din_ch];
  assign cur_v5    = v5_row(off_all[din_ch]);
  assign cur_ptr   = (cur_row == 8'd0) || (cur_row == 8'd36) ||
                     (cur_row == 8'd72) || (cur_row == 8'd108);
  assign cur_is_v5 = !cur_ptr && (cur_row == cur_v5);
  assign byte_par  = {^(datain[7:0] & 8'hAA), ^(datain[7:0] & 8'h55)};
  assign wr_req    = din_hit && !cur_ptr && !cur_is_v5;
  // Idle channel slots report count 0, so reads of them underflow
  assign rd_ok     = rd_en && (cnt_all[rd_ch] != '0);
  // A read of the same full channel frees a slot for this write
  assign wr_ok     = wr_req && ((cnt_all[din_ch] != FULL) || (rd_ok && (rd_ch == din_ch)));
  assign rei_fire  = din_hit && cur_is_v5 && bip_ok_all[din_ch];

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_ch
      if (gi < NCH) begin : g_live
        logic          sel;
        logic          apply;
        logic          flush;
        logic          wr_here;
        logic          rd_here;
        logic [7:0]    row_reg;
        logic [9:0]    off_reg;
        logic [9:0]    pend_reg;
        logic [1:0]    acc_reg;
        logic          bip_ok_reg;
        logic [PW-1:0] wptr_reg;
        logic [PW-1:0] rptr_reg;
        logic [CW-1:0] cnt_reg;

        assign sel     = din_hit && (din_ch == CHW'(gi));
        // Pending offset takes effect at the multiframe boundary
        assign apply   = rxsof || (sel && (row_reg == 8'd143));
        assign flush   = apply && (pend_reg != off_reg);
        assign wr_here = wr_ok && (din_ch == CHW'(gi));
        assign rd_here = rd_ok && (rd_ch == CHW'(gi));

        // Row tracking, pointer offset handover and BIP-2 accumulation
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            row_reg    <= '0;
            off_reg    <= '0;
            pend_reg   <= '0;
            acc_reg    <= '0;
            bip_ok_reg <= 1'b0;
          end else begin
            if (ptr_vld && (ptr_ch == CHW'(gi)) && (ptr_off <= 10'd139))
              pend_reg <= ptr_off;
            if (rxsof)
              row_reg <= '0;
            else if (sel)
              row_reg <= (row_reg == 8'd143) ? 8'd0 : row_reg + 8'd1;
            if (sel && !cur_ptr) begin
              if (cur_is_v5) begin
                acc_reg    <= byte_par;
                bip_ok_reg <= 1'b1;
              end else begin
                acc_reg <= acc_reg ^ byte_par;
              end
            end
            // A changed offset invalidates the running BIP; this wins over a V5 at row 143
            if (apply) begin
              off_reg <= pend_reg;
              if (pend_reg != off_reg)
                bip_ok_reg <= 1'b0;
            end
          end
        end

        // FIFO pointers; a flush empties the channel regardless of same-cycle traffic
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            cnt_reg  <= '0;
          end else if (flush) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            cnt_reg  <= '0;
          end else begin
            if (wr_here) wptr_reg <= wptr_reg + PW'(1);
            if (rd_here) rptr_reg <= rptr_reg + PW'(1);
            cnt_reg <= cnt_reg + CW'(wr_here) - CW'(rd_here);
          end
        end

        assign row_all[gi]    = row_reg;
        assign off_all[gi]    = off_reg;
        assign acc_all[gi]    = acc_reg;
        assign bip_ok_all[gi] = bip_ok_reg;
        assign wptr_all[gi]   = wptr_reg;
        assign rptr_all[gi]   = rptr_reg;
        assign cnt_all[gi]    = cnt_reg;
      end else begin : g_idle
        assign row_all[gi]    = '0;
        assign off_all[gi]    = '0;
        assign acc_all[gi]    = '0;
        assign bip_ok_all[gi] = 1'b0;
        assign wptr_all[gi]   = '0;
        assign rptr_all[gi]   = '0;
        assign cnt_all[gi]    = '0;
      end
    end
  endgenerate

  // Shared payload RAM write port
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[{din_ch, wptr_all[din_ch]}] <= datain;
  end

  // Registered read data, REI report and error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      rei_vld  <= 1'b0;
      rei_ch   <= '0;
      rei_bip2 <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      dout_vld <= rd_ok;
      if (rd_ok)
        dout <= mem[{rd_ch, rptr_all[rd_ch]}];
      rei_vld <= rei_fire;
      if (rei_fire) begin
        rei_ch   <= din_ch;
        rei_bip2 <= |(acc_all[din_ch] ^ datain[7:6]);
      end
      ovf <= wr_req && !wr_ok;
      unf <= rd_en && !rd_ok;
    end
  end

endmodule

// File: tb/tb_egr_tu12_mc.sv
// tb_egr_tu12_mc: directed bench for the multichannel TU-12 egress demapper.
module tb_egr_tu12_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxsof;
  logic       din_vld;
  logic [4:0] din_ch;
  logic [7:0] datain;
  logic       ptr_vld;
  logic [4:0] ptr_ch;
  logic [9:0] ptr_off;
  logic       rd_en;
  logic [4:0] rd_ch;
  logic [7:0] dout;
  logic       dout_vld;
  logic       rei_vld;
  logic [4:0] rei_ch;
  logic       rei_bip2;
  logic       ovf;
  logic       unf;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         mfseq  = 0;
  logic [1:0] acc_m [21];
  logic [7:0] expq [$];

  always #5 clk = ~clk;

  egr_tu12_mc #(.WIDTH(8), .NCH(21), .CHW(5), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .rxsof(rxsof),
    .din_vld(din_vld), .din_ch(din_ch), .datain(datain),
    .ptr_vld(ptr_vld), .ptr_ch(ptr_ch), .ptr_off(ptr_off),
    .rd_en(rd_en), .rd_ch(rd_ch),
    .dout(dout), .dout_vld(dout_vld),
    .rei_vld(rei_vld), .rei_ch(rei_ch), .rei_bip2(rei_bip2),
    .ovf(ovf), .unf(unf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rxsof = 0; din_vld = 0; din_ch = 0; datain = 0;
    ptr_vld = 0; ptr_ch = 0; ptr_off = 0; rd_en = 0; rd_ch = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] par(input logic [7:0] b);
    return {^(b & 8'hAA), ^(b & 8'h55)};
  endfunction

  task automatic wr(input int ch, input logic [7:0] d, input bit exp_ovf);
    din_vld = 1; din_ch = 5'(ch); datain = d;
    step();
    $display("wr ch%0d data %02h ovf %0b", ch, d, ovf);
    chk("wr_ovf", ovf, exp_ovf);
    idle();
  endtask

  task automatic rd(input int ch, input bit exp_vld, input logic [7:0] exp_d);
    rd_en = 1; rd_ch = 5'(ch);
    step();
    $display("rd ch%0d vld %0b data %02h unf %0b", ch, dout_vld, dout, unf);
    chk("rd_vld", dout_vld, exp_vld);
    if (exp_vld) chk("rd_data", dout, exp_d);
    else         chk("rd_unf", unf, 1);
    idle();
  endtask

  task automatic drain(input int ch);
    rd_en = 1; rd_ch = 5'(ch);
    step();
    if (dout_vld) begin
      if (expq.size() == 0) chk("drain_extra", dout_vld, 0);
      else                  chk("drain_data", dout, expq.pop_front());
    end
    idle();
    chk("drain_left", expq.size(), 0);
  endtask

  // One 144-byte multiframe on channel ch with V5 at row v5r. With rd set the
  // channel is read every cycle and every byte coming out is matched against
  // the expected payload stream. prow/poff inject a pointer update mid-frame.
  task automatic send_mf(input int ch, input int v5r, input bit corrupt, input bit rd,
                         input int prow, input int poff,
                         output int n_rei, output int r_row, output int r_bip);
    n_rei = 0; r_row = -1; r_bip = -1;
    for (int r = 0; r < 144; r++) begin
      logic [7:0] b;
      b = 8'(r * 5 + ch * 11 + mfseq * 3);
      if (r == v5r) b[7:6] = acc_m[ch] ^ {corrupt, 1'b0};
      if (!(r == 0 || r == 36 || r == 72 || r == 108)) begin
        if (r == v5r) acc_m[ch] = par(b);
        else begin
          acc_m[ch] = acc_m[ch] ^ par(b);
          if (rd) expq.push_back(b);
        end
      end
      din_vld = 1; din_ch = 5'(ch); datain = b;
      rd_en = rd; rd_ch = 5'(ch);
      ptr_vld = (r == prow); ptr_ch = 5'(ch); ptr_off = 10'(poff);
      step();
      if (rei_vld) begin
        n_rei++; r_row = r; r_bip = int'(rei_bip2);
        chk("rei_ch", rei_ch, ch);
      end
      if (dout_vld) begin
        if (expq.size() == 0) chk("fifo_extra", dout_vld, 0);
        else                  chk("fifo_data", dout, expq.pop_front());
      end
    end
    idle();
    mfseq++;
    $display("mf ch%0d v5row %0d rei_count %0d rei_row %0d rei_bip2 %0d", ch, v5r, n_rei, r_row, r_bip);
  endtask

  initial begin
    int n, rr, rb;
    int t3_ch [4];
    int t3_off [4];
    int t3_row [4];
    t3_ch  = '{7, 8, 9, 10};
    t3_off = '{34, 35, 105, 139};
    t3_row = '{71, 73, 1, 35};
    for (int i = 0; i < 21; i++) acc_m[i] = 2'b00;

    // T1: reset values, then reset in the middle of traffic
    idle();
    rst = 1;
    #2 rst = 0;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_rei_vld", rei_vld, 0);
    chk("rst_rei_ch", rei_ch, 0);
    chk("rst_rei_bip2", rei_bip2, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    wr(1, 8'h11, 0);             // row 0: pointer byte, discarded
    wr(1, 8'h12, 0);
    wr(1, 8'h13, 0);
    rd(1, 1, 8'h12);
    #2 rst = 0;
    #1;
    chk("t1_midrst_dout_vld", dout_vld, 0);
    chk("t1_midrst_dout", dout, 0);
    @(posedge clk);
    #1 rst = 1;
    rd(1, 0, 8'h00);

    // T2: ch3 offset 0, V5 at row 37, rei from second multiframe on
    ptr_vld = 1; ptr_ch = 3; ptr_off = 0; step(); idle();
    rxsof = 1; step(); idle();
    send_mf(3, 37, 0, 1, -1, 0, n, rr, rb);
    chk("t2_mf1_rei_cnt", n, 0);
    send_mf(3, 37, 0, 1, -1, 0, n, rr, rb);
    chk("t2_mf2_rei_cnt", n, 1);
    chk("t2_mf2_rei_row", rr, 37);
    chk("t2_mf2_bip2", rb, 0);
    send_mf(3, 37, 1, 1, -1, 0, n, rr, rb);
    chk("t2_mf3_rei_cnt", n, 1);
    chk("t2_mf3_bip2", rb, 1);
    drain(3);

    // T3: offset to V5 row mapping at the range boundaries
    for (int i = 0; i < 4; i++) begin
      ptr_vld = 1; ptr_ch = 5'(t3_ch[i]); ptr_off = 10'(t3_off[i]); step(); idle();
    end
    rxsof = 1; step(); idle();
    for (int i = 0; i < 4; i++) begin
      send_mf(t3_ch[i], t3_row[i], 0, 1, -1, 0, n, rr, rb);
      chk("t3_mf1_rei_cnt", n, 0);
      send_mf(t3_ch[i], t3_row[i], 0, 1, -1, 0, n, rr, rb);
      chk("t3_mf2_rei_cnt", n, 1);
      chk("t3_mf2_rei_row", rr, t3_row[i]);
      chk("t3_mf2_bip2", rb, 0);
      drain(t3_ch[i]);
    end

    // T4: ch0 overflow on the 9th payload byte, then read back and underflow
    for (int r = 0; r < 10; r++) wr(0, 8'(8'hA0 + r), (r == 9));
    for (int r = 1; r < 9; r++) rd(0, 1, 8'(8'hA0 + r));
    rd(0, 0, 8'h00);

    // T5: ch0/ch20 interleaved, write+read on full ch20 in one cycle
    for (int k = 0; k < 9; k++) begin
      wr(20, 8'(8'h20 + k), 0);  // k=0 is the row-0 pointer byte
      if (k < 4) wr(0, 8'(8'h60 + k), 0);
    end
    din_vld = 1; din_ch = 20; datain = 8'h29; rd_en = 1; rd_ch = 20;
    step();
    $display("wr+rd ch20 data 29 ovf %0b vld %0b dout %02h", ovf, dout_vld, dout);
    chk("t5_full_wr_ovf", ovf, 0);
    chk("t5_full_rd_vld", dout_vld, 1);
    chk("t5_full_rd_data", dout, 8'h21);
    idle();
    for (int k = 2; k < 10; k++) rd(20, 1, 8'(8'h20 + k));
    rd(20, 0, 8'h00);
    for (int k = 0; k < 4; k++) rd(0, 1, 8'(8'h60 + k));

    // T6: mid-frame pointer change on ch5 takes effect only at the wrap
    send_mf(5, 37, 0, 1, -1, 0, n, rr, rb);
    chk("t6_mf1_rei_cnt", n, 0);
    drain(5);
    send_mf(5, 37, 0, 0, 10, 10, n, rr, rb);
    chk("t6_mf2_rei_cnt", n, 1);
    chk("t6_mf2_rei_row", rr, 37);
    rd(5, 0, 8'h00);             // FIFO flushed at the wrap
    send_mf(5, 47, 0, 1, -1, 0, n, rr, rb);
    chk("t6_mf3_rei_cnt", n, 0);
    send_mf(5, 47, 0, 1, -1, 0, n, rr, rb);
    chk("t6_mf4_rei_cnt", n, 1);
    chk("t6_mf4_rei_row", rr, 47);
    chk("t6_mf4_bip2", rb, 0);
    drain(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
